// File: rtl/board_engine.sv
`default_nettype none
// board_engine: 2048 game-state engine. Holds the 4x4 board, slides/merges one line
// per cycle, spawns tiles from an LFSR and flags win / game-over.
module board_engine #(
    parameter logic [15:0] LFSR_SEED  = 16'hACE1,
    parameter bit          SPAWN_EN   = 1'b1,
    parameter int          INIT_TILES = 2
) (
    input  logic        ClkPort,
    input  logic        Reset_n,
    input  logic        move_valid,
    input  logic [1:0]  move_dir,
    output logic        move_ready,
    input  logic        load_valid,
    input  logic [3:0]  load_idx,
    input  logic [10:0] load_val,
    output logic [10:0] number1,  number2,  number3,  number4,
    output logic [10:0] number5,  number6,  number7,  number8,
    output logic [10:0] number9,  number10, number11, number12,
    output logic [10:0] number13, number14, number15, number16,
    output logic [15:0] score,
    output logic        moved,
    output logic        won,
    output logic        game_over
);

    localparam logic [2:0] S_INIT  = 3'd0;
    localparam logic [2:0] S_IDLE  = 3'd1;
    localparam logic [2:0] S_LINE0 = 3'd2;
    localparam logic [2:0] S_LINE1 = 3'd3;
    localparam logic [2:0] S_LINE2 = 3'd4;
    localparam logic [2:0] S_LINE3 = 3'd5;
    localparam logic [2:0] S_SPAWN = 3'd6;
    localparam logic [2:0] S_CHECK = 3'd7;

    logic [2:0]         state_q, state_d;
    logic [15:0][10:0]  board_q, board_d;
    logic [15:0]        lfsr_q, lfsr_d;
    logic [15:0]        score_q, score_d;
    logic [1:0]         dir_q, dir_d;
    logic               changed_q, changed_d;
    logic               won_q, won_d;
    logic               over_q, over_d;
    logic [3:0]         sidx_q, sidx_d;
    logic [4:0]         scnt_q, scnt_d;
    logic [1:0]         init_q, init_d;

    logic [1:0]         w_line_sel;
    logic [3:0][10:0]   w_line_in, w_line_out;
    logic [15:0]        w_line_gain;
    logic [16:0]        w_score_sum;
    logic [3:0]         w_sp_idx;
    logic               w_sp_empty, w_sp_done, w_spawning;
    logic [10:0]        w_sp_val;
    logic               w_any_empty, w_any_pair, w_any_2048;

    // Position 0 of a gathered line is the cell on the destination edge.
    function automatic logic [3:0] cell_idx(input logic [1:0] dir, input logic [1:0] line,
                                            input logic [1:0] pos);
        case (dir)
            2'b00:   cell_idx = {pos, line};
            2'b01:   cell_idx = {~pos, line};
            2'b10:   cell_idx = {line, pos};
            default: cell_idx = {line, ~pos};
        endcase
    endfunction

    function automatic logic [3:0][10:0] compress(input logic [3:0][10:0] a);
        logic [3:0][10:0] r;
        logic [1:0]       k;
        r = '0;
        k = 2'd0;
        for (int i = 0; i < 4; i++) begin
            if (a[i] != '0) begin
                r[k] = a[i];
                k    = k + 2'd1;
            end
        end
        return r;
    endfunction

    function automatic logic [3:0][10:0] slide(input logic [3:0][10:0] a, output logic [15:0] gain);
        logic [3:0][10:0] c;
        logic             skip;
        c    = compress(a);
        skip = 1'b0;
        gain = '0;
        for (int j = 0; j < 3; j++) begin
            if (skip) begin
                skip = 1'b0;
            end else if (c[j] != '0 && c[j] == c[j+1] && c[j] != 11'h400) begin
                c[j]   = c[j] << 1;
                c[j+1] = '0;
                gain   = gain + {4'b0, c[j], 1'b0};
                skip   = 1'b1;
            end
        end
        return compress(c);
    endfunction

    always_comb begin
        w_line_sel = 2'(state_q - S_LINE0);
        for (int p = 0; p < 4; p++) begin
            w_line_in[p] = board_q[cell_idx(dir_q, w_line_sel, 2'(p))];
        end
        w_line_out  = slide(w_line_in, w_line_gain);
        w_score_sum = {1'b0, score_q} + {1'b0, w_line_gain};
    end

    // The first probe of a spawn starts at a random cell; later probes walk forward.
    assign w_sp_idx   = (scnt_q == 5'd0) ? lfsr_q[3:0] : sidx_q;
    assign w_sp_empty = (board_q[w_sp_idx] == '0);
    assign w_sp_val   = (lfsr_q[7:4] == 4'd0) ? 11'd2 : 11'd1;
    assign w_sp_done  = w_sp_empty || (scnt_q == 5'd15);
    assign w_spawning = (state_q == S_SPAWN) || (state_q == S_INIT && init_q != 2'd0);

    always_comb begin
        w_any_empty = 1'b0;
        w_any_pair  = 1'b0;
        w_any_2048  = 1'b0;
        for (int i = 0; i < 16; i++) begin
            if (board_q[i] == '0)     w_any_empty = 1'b1;
            if (board_q[i] == 11'h400) w_any_2048 = 1'b1;
        end
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 3; c++)
                if (board_q[4*r+c] == board_q[4*r+c+1]) w_any_pair = 1'b1;
        for (int r = 0; r < 3; r++)
            for (int c = 0; c < 4; c++)
                if (board_q[4*r+c] == board_q[4*r+c+4]) w_any_pair = 1'b1;
    end

    always_comb begin
        state_d   = state_q;
        board_d   = board_q;
        lfsr_d    = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
        score_d   = score_q;
        dir_d     = dir_q;
        changed_d = changed_q;
        won_d     = won_q;
        over_d    = over_q;
        sidx_d    = sidx_q;
        scnt_d    = scnt_q;
        init_d    = init_q;

        if (w_spawning) begin
            if (w_sp_empty) board_d[w_sp_idx] = w_sp_val;
            scnt_d = w_sp_done ? 5'd0 : scnt_q + 5'd1;
            sidx_d = w_sp_idx + 4'd1;
        end

        case (state_q)
            S_INIT: begin
                if (init_q == 2'd0) begin
                    state_d = S_IDLE;
                end else if (w_sp_done) begin
                    init_d = init_q - 2'd1;
                    if (init_q == 2'd1) state_d = S_IDLE;
                end
            end
            S_IDLE: begin
                if (move_valid && move_ready) begin
                    dir_d     = move_dir;
                    changed_d = 1'b0;
                    state_d   = S_LINE0;
                end else if (load_valid) begin
                    board_d[load_idx] = load_val;
                end
            end
            S_LINE0, S_LINE1, S_LINE2, S_LINE3: begin
                for (int p = 0; p < 4; p++) begin
                    board_d[cell_idx(dir_q, w_line_sel, 2'(p))] = w_line_out[p];
                end
                changed_d = changed_q | (w_line_out != w_line_in);
                score_d   = w_score_sum[16] ? 16'hFFFF : w_score_sum[15:0];
                if (state_q == S_LINE3)
                    state_d = (changed_d && SPAWN_EN) ? S_SPAWN : S_CHECK;
                else
                    state_d = state_q + 3'd1;
            end
            S_SPAWN: begin
                if (w_sp_done) state_d = S_CHECK;
            end
            S_CHECK: begin
                won_d   = won_q | w_any_2048;
                over_d  = over_q | (!w_any_empty && !w_any_pair);
                state_d = S_IDLE;
            end
            default: state_d = S_INIT;
        endcase
    end

    always_ff @(posedge ClkPort or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q   <= S_INIT;
            board_q   <= '0;
            lfsr_q    <= LFSR_SEED;
            score_q   <= '0;
            dir_q     <= 2'd0;
            changed_q <= 1'b0;
            won_q     <= 1'b0;
            over_q    <= 1'b0;
            sidx_q    <= 4'd0;
            scnt_q    <= 5'd0;
            init_q    <= 2'(INIT_TILES);
        end else begin
            state_q   <= state_d;
            board_q   <= board_d;
            lfsr_q    <= lfsr_d;
            score_q   <= score_d;
            dir_q     <= dir_d;
            changed_q <= changed_d;
            won_q     <= won_d;
            over_q    <= over_d;
            sidx_q    <= sidx_d;
            scnt_q    <= scnt_d;
            init_q    <= init_d;
        end
    end

    assign move_ready = (state_q == S_IDLE) && !over_q;
    assign moved      = (state_q == S_CHECK) && changed_q;
    assign won        = won_q;
    assign game_over  = over_q;
    assign score      = score_q;

    assign number1  = board_q[0];
    assign number2  = board_q[1];
    assign number3  = board_q[2];
    assign number4  = board_q[3];
    assign number5  = board_q[4];
    assign number6  = board_q[5];
    assign number7  = board_q[6];
    assign number8  = board_q[7];
    assign number9  = board_q[8];
    assign number10 = board_q[9];
    assign number11 = board_q[10];
    assign number12 = board_q[11];
    assign number13 = board_q[12];
    assign number14 = board_q[13];
    assign number15 = board_q[14];
    assign number16 = board_q[15];

endmodule
`default_nettype wire

// File: tb/tb_board_engine.sv
`default_nettype none
// tb_board_engine: directed vectors for the 2048 board engine (deterministic and default builds).
`timescale 1ns/1ps
module tb_board_engine;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        mv_valid;
    logic [1:0]  mv_dir;
    logic        ld_valid;
    logic [3:0]  ld_idx;
    logic [10:0] ld_val;
    logic [10:0] num [16];
    logic [15:0] score;
    logic        ready, moved, won, over;

    logic        d_mv_valid = 1'b0;
    logic [1:0]  d_mv_dir   = 2'd0;
    logic        d_ld_valid = 1'b0;
    logic [3:0]  d_ld_idx   = 4'd0;
    logic [10:0] d_ld_val   = 11'd0;
    logic [10:0] dnum [16];
    logic [15:0] dscore;
    logic        dready, dmoved, dwon, dover;

    board_engine #(.LFSR_SEED(16'hACE1), .SPAWN_EN(1'b0), .INIT_TILES(0)) dut (
        .ClkPort(clk), .Reset_n(rst_n), .move_valid(mv_valid), .move_dir(mv_dir),
        .move_ready(ready), .load_valid(ld_valid), .load_idx(ld_idx), .load_val(ld_val),
        .number1(num[0]),   .number2(num[1]),   .number3(num[2]),   .number4(num[3]),
        .number5(num[4]),   .number6(num[5]),   .number7(num[6]),   .number8(num[7]),
        .number9(num[8]),   .number10(num[9]),  .number11(num[10]), .number12(num[11]),
        .number13(num[12]), .number14(num[13]), .number15(num[14]), .number16(num[15]),
        .score(score), .moved(moved), .won(won), .game_over(over));

    board_engine dut_def (
        .ClkPort(clk), .Reset_n(rst_n), .move_valid(d_mv_valid), .move_dir(d_mv_dir),
        .move_ready(dready), .load_valid(d_ld_valid), .load_idx(d_ld_idx), .load_val(d_ld_val),
        .number1(dnum[0]),   .number2(dnum[1]),   .number3(dnum[2]),   .number4(dnum[3]),
        .number5(dnum[4]),   .number6(dnum[5]),   .number7(dnum[6]),   .number8(dnum[7]),
        .number9(dnum[8]),   .number10(dnum[9]),  .number11(dnum[10]), .number12(dnum[11]),
        .number13(dnum[12]), .number14(dnum[13]), .number15(dnum[14]), .number16(dnum[15]),
        .score(dscore), .moved(dmoved), .won(dwon), .game_over(dover));

    typedef struct {
        logic [1:0]       dir;
        logic [1:0]       line;
        logic [3:0][10:0] a;
        logic [3:0][10:0] e;
        logic [15:0]      gain;
        logic             mv;
    } vec_t;

    int n_vec = 0;
    int n_bad = 0;
    int moved_cnt = 0;

    always @(negedge clk) if (moved === 1'b1) moved_cnt++;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Board cell for position pos of a line, counted from the destination edge.
    function automatic int phys(input logic [1:0] dir, input int line, input int pos);
        case (dir)
            2'b00:   return pos * 4 + line;
            2'b01:   return (3 - pos) * 4 + line;
            2'b10:   return line * 4 + pos;
            default: return line * 4 + (3 - pos);
        endcase
    endfunction

    function automatic vec_t mk(input logic [1:0] d, input logic [1:0] l,
                                input logic [10:0] a0, a1, a2, a3, e0, e1, e2, e3,
                                input logic [15:0] g, input logic m);
        vec_t r;
        r.dir = d; r.line = l; r.gain = g; r.mv = m;
        r.a[0] = a0; r.a[1] = a1; r.a[2] = a2; r.a[3] = a3;
        r.e[0] = e0; r.e[1] = e1; r.e[2] = e2; r.e[3] = e3;
        return r;
    endfunction

    // All tasks start and end on a falling edge.
    task automatic load_cell(input logic [3:0] idx, input logic [10:0] val);
        ld_valid = 1'b1; ld_idx = idx; ld_val = val;
        @(negedge clk);
        ld_valid = 1'b0;
    endtask

    task automatic clear_board();
        for (int k = 0; k < 16; k++) load_cell(4'(k), 11'd0);
    endtask

    task automatic do_move(input logic [1:0] d, output int lat);
        mv_valid = 1'b1; mv_dir = d;
        @(negedge clk);
        mv_valid = 1'b0;
        lat = 0;
        while (ready !== 1'b1 && lat < 40) begin
            @(negedge clk);
            lat++;
        end
    endtask

    initial begin
        vec_t        tv [12];
        logic [10:0] expb [16];
        int          lat, exp_score, mc0, cnt, badv;

        tv[0]  = mk(2'b10, 2'd0, 11'd1, 11'd1, 11'd1, 11'd1, 11'd2, 11'd2, 11'd0, 11'd0, 16'd8, 1'b1);
        tv[1]  = mk(2'b00, 2'd0, 11'd2, 11'd0, 11'd2, 11'd4, 11'd4, 11'd4, 11'd0, 11'd0, 16'd8, 1'b1);
        tv[2]  = mk(2'b10, 2'd0, 11'd1, 11'd2, 11'd4, 11'd8, 11'd1, 11'd2, 11'd4, 11'd8, 16'd0, 1'b0);
        tv[3]  = mk(2'b11, 2'd1, 11'd1, 11'd1, 11'd0, 11'd0, 11'd2, 11'd0, 11'd0, 11'd0, 16'd4, 1'b1);
        tv[4]  = mk(2'b01, 2'd2, 11'd0, 11'd1, 11'd1, 11'd1, 11'd2, 11'd1, 11'd0, 11'd0, 16'd4, 1'b1);
        tv[5]  = mk(2'b10, 2'd3, 11'h200, 11'h200, 11'd0, 11'd0, 11'h400, 11'd0, 11'd0, 11'd0, 16'd2048, 1'b1);
        tv[6]  = mk(2'b10, 2'd2, 11'h400, 11'h400, 11'd0, 11'd0, 11'h400, 11'h400, 11'd0, 11'd0, 16'd0, 1'b0);
        tv[7]  = mk(2'b00, 2'd3, 11'd0, 11'd0, 11'd0, 11'd1, 11'd1, 11'd0, 11'd0, 11'd0, 16'd0, 1'b1);
        tv[8]  = mk(2'b10, 2'd0, 11'd2, 11'd2, 11'd4, 11'd4, 11'd4, 11'd8, 11'd0, 11'd0, 16'd24, 1'b1);
        tv[9]  = mk(2'b11, 2'd2, 11'd1, 11'd0, 11'd1, 11'd2, 11'd2, 11'd2, 11'd0, 11'd0, 16'd4, 1'b1);
        tv[10] = mk(2'b01, 2'd1, 11'd8, 11'd8, 11'd8, 11'd8, 11'h10, 11'h10, 11'd0, 11'd0, 16'd64, 1'b1);
        tv[11] = mk(2'b00, 2'd2, 11'h400, 11'h200, 11'h200, 11'h400, 11'h400, 11'h400, 11'h400, 11'd0, 16'd2048, 1'b1);

        rst_n = 1'b0; mv_valid = 1'b0; mv_dir = 2'd0;
        ld_valid = 1'b0; ld_idx = 4'd0; ld_val = 11'd0;
        repeat (3) @(negedge clk);
        chk("reset num1", 32'(num[0]), 32'd0);
        chk("reset num16", 32'(num[15]), 32'd0);
        chk("reset score", 32'(score), 32'd0);
        chk("reset ready", 32'(ready), 32'd0);
        chk("reset won/over/moved", 32'({won, over, moved}), 32'd0);
        rst_n = 1'b1;

        // Default build: two spawned tiles after INIT.
        lat = 0;
        while (dready !== 1'b1 && lat < 60) begin @(negedge clk); lat++; end
        chk("T1 ready", 32'(dready), 32'd1);
        cnt = 0; badv = 0;
        for (int k = 0; k < 16; k++) begin
            if (dnum[k] != 11'd0) cnt++;
            if (dnum[k] != 11'd0 && dnum[k] != 11'd1 && dnum[k] != 11'd2) badv++;
        end
        chk("T1 tile count", 32'(cnt), 32'd2);
        chk("T1 bad tile values", 32'(badv), 32'd0);
        chk("T1 score", 32'(dscore), 32'd0);
        chk("idle ready", 32'(ready), 32'd1);

        exp_score = 0;
        for (int v = 0; v < 12; v++) begin
            clear_board();
            for (int p = 0; p < 4; p++)
                if (tv[v].a[p] != 11'd0) load_cell(4'(phys(tv[v].dir, int'(tv[v].line), p)), tv[v].a[p]);
            for (int k = 0; k < 16; k++) expb[k] = 11'd0;
            for (int p = 0; p < 4; p++) expb[phys(tv[v].dir, int'(tv[v].line), p)] = tv[v].e[p];
            mc0 = moved_cnt;
            do_move(tv[v].dir, lat);
            exp_score = exp_score + int'(tv[v].gain);
            if (exp_score > 65535) exp_score = 65535;
            chk($sformatf("v%0d latency", v), 32'(lat), 32'd5);
            for (int k = 0; k < 16; k++)
                chk($sformatf("v%0d cell%0d", v, k), 32'(num[k]), 32'(expb[k]));
            chk($sformatf("v%0d score", v), 32'(score), 32'(exp_score));
            chk($sformatf("v%0d moved pulses", v), 32'(moved_cnt - mc0), 32'(tv[v].mv));
        end
        chk("won sticky", 32'(won), 32'd1);
        chk("no game over", 32'(over), 32'd0);

        // Move and load in the same cycle: the move is taken, the load dropped.
        clear_board();
        load_cell(4'd0, 11'd1);
        ld_valid = 1'b1; ld_idx = 4'd5; ld_val = 11'd3;
        do_move(2'b11, lat);
        ld_valid = 1'b0;
        chk("collision cell3", 32'(num[3]), 32'd1);
        chk("collision cell5", 32'(num[5]), 32'd0);
        chk("collision cell0", 32'(num[0]), 32'd0);

        // Score saturation.
        for (int i = 0; i < 16; i++) begin
            clear_board();
            for (int k = 0; k < 4; k++) load_cell(4'(k), 11'h200);
            do_move(2'b10, lat);
        end
        chk("score saturate", 32'(score), 32'h0000FFFF);

        // Checkerboard: no move possible -> game over.
        for (int k = 0; k < 16; k++) load_cell(4'(k), ((((k >> 2) + (k & 3)) & 1) != 0) ? 11'd2 : 11'd1);
        mc0 = moved_cnt;
        do_move(2'b10, lat);
        badv = 0;
        for (int k = 0; k < 16; k++)
            if (num[k] != (((((k >> 2) + (k & 3)) & 1) != 0) ? 11'd2 : 11'd1)) badv++;
        chk("T5 board changed cells", 32'(badv), 32'd0);
        chk("T5 game_over", 32'(over), 32'd1);
        chk("T5 move_ready", 32'(ready), 32'd0);
        chk("T5 moved pulses", 32'(moved_cnt - mc0), 32'd0);

        // Asynchronous reset in the middle of a move.
        rst_n = 1'b0;
        #2 rst_n = 1'b1;
        @(negedge clk);
        lat = 0;
        while (ready !== 1'b1 && lat < 10) begin @(negedge clk); lat++; end
        load_cell(4'd0, 11'd1);
        load_cell(4'd1, 11'd1);
        mv_valid = 1'b1; mv_dir = 2'b10;
        @(negedge clk);
        mv_valid = 1'b0;
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        badv = 0;
        for (int k = 0; k < 16; k++) if (num[k] != 11'd0) badv++;
        chk("T7 cells cleared", 32'(badv), 32'd0);
        chk("T7 score", 32'(score), 32'd0);
        chk("T7 flags", 32'({ready, moved, won, over}), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        lat = 0;
        while (ready !== 1'b1 && lat < 10) begin @(negedge clk); lat++; end
        chk("T7 restart ready", 32'(ready), 32'd1);
        chk("T7 restart cell0", 32'(num[0]), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
